// File: rtl/spram_access_pkg.sv
// spram_access_pkg: size encodings, controller states and lane masks shared by the SPRAM initiator
package spram_access_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_CAPTURE, ST_RESP, ST_STANDBY, ST_WAKE} state_e;
    localparam logic [7:0] MASK_BYTE = 8'h03;
    localparam logic [7:0] MASK_HALF = 8'h0F;
    localparam logic [7:0] MASK_WORD = 8'hFF;
    function automatic logic bad_access(input size_e s, input logic [1:0] o);
        return s == SZ_ILL || (s == SZ_HALF && o[0]) || (s == SZ_WORD && o != 2'b00);
    endfunction
endpackage

// File: rtl/spram_access_ctrl_if.sv
// spram_access_ctrl_if: processor request/response and SPRAM port bundle
interface spram_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [14:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [7:0]  mem_mask_wren;
    logic        mem_wren;
    logic        mem_chip_sel;
    logic        mem_standby;
    logic        mem_sleep;
    logic        mem_poweroff;
    logic [31:0] mem_data_out;
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_data_in, mem_mask_wren,
               mem_wren, mem_chip_sel, mem_standby, mem_sleep, mem_poweroff
    );
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_data_in, mem_mask_wren,
               mem_wren, mem_chip_sel, mem_standby, mem_sleep, mem_poweroff
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane replication/nibble mask and load lane extraction/extension
module mem_lane_align
    import spram_access_pkg::*;
(
    input  size_e       i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_data,
    output logic [7:0]  o_st_mask,
    input  size_e       i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_data,
    output logic [31:0] o_ld_data
);
    logic [31:0] w_shifted;
    always_comb begin
        o_st_data = i_st_size == SZ_BYTE ? {4{i_st_data[7:0]}} :
                    i_st_size == SZ_HALF ? {2{i_st_data[15:0]}} : i_st_data;
        o_st_mask = i_st_size == SZ_BYTE ? MASK_BYTE << {i_st_off, 1'b0} :
                    i_st_size == SZ_HALF ? MASK_HALF << {i_st_off[1], 2'b00} : MASK_WORD;
        w_shifted = i_ld_data >> {i_ld_off, 3'b000};
        o_ld_data = i_ld_size == SZ_BYTE ? {{24{~i_ld_unsigned & w_shifted[7]}}, w_shifted[7:0]} :
                    i_ld_size == SZ_HALF ? {{16{~i_ld_unsigned & w_shifted[15]}}, w_shifted[15:0]} : w_shifted;
    end
endmodule

// File: rtl/spram_access_ctrl.sv
// spram_access_ctrl: single-outstanding load/store initiator for the banked SPRAM with idle standby
module spram_access_ctrl
    import spram_access_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    spram_access_ctrl_if.slave bus
);
    localparam logic [7:0] LAST_IDLE = 8'(IDLE_TIMEOUT - 1);
    state_e      r_state;
    logic [7:0]  r_idle_cnt;
    logic        r_ready, r_rsp_valid, r_rsp_err, r_wren, r_cs, r_standby;
    logic [31:0] r_rsp_rdata, r_din;
    logic [14:0] r_addr;
    logic [7:0]  r_mask;
    logic        r_write, r_unsigned;
    size_e       r_size;
    logic [1:0]  r_off;
    size_e       w_size;
    logic [31:0] w_st_data, w_ld_data;
    logic [7:0]  w_st_mask;
    assign w_size = size_e'(bus.req_size);
    mem_lane_align u_align (
        .i_st_size(w_size), .i_st_off(bus.req_addr[1:0]), .i_st_data(bus.req_wdata),
        .o_st_data(w_st_data), .o_st_mask(w_st_mask),
        .i_ld_size(r_size), .i_ld_off(r_off), .i_ld_unsigned(r_unsigned),
        .i_ld_data(bus.mem_data_out), .o_ld_data(w_ld_data)
    );
    assign bus.req_ready     = r_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_data_in   = r_din;
    assign bus.mem_mask_wren = r_mask;
    assign bus.mem_wren      = r_wren;
    assign bus.mem_chip_sel  = r_cs;
    assign bus.mem_standby   = r_standby;
    assign bus.mem_sleep     = 1'b0;
    assign bus.mem_poweroff  = 1'b0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idle_cnt  <= '0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_mask      <= '0;
            r_wren      <= 1'b0;
            r_cs        <= 1'b0;
            r_standby   <= 1'b0;
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_size      <= SZ_BYTE;
            r_off       <= '0;
        end else begin
            r_idle_cnt <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_ready    <= 1'b0;
                        r_write    <= bus.req_write;
                        r_unsigned <= bus.req_unsigned;
                        r_size     <= w_size;
                        r_off      <= bus.req_addr[1:0];
                        if (bad_access(w_size, bus.req_addr[1:0])) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_cs    <= 1'b1;
                            r_wren  <= bus.req_write;
                            r_addr  <= bus.req_addr[16:2];
                            r_din   <= w_st_data;
                            r_mask  <= bus.req_write ? w_st_mask : 8'h00;
                            r_state <= ST_ACCESS;
                        end
                    end else if (r_idle_cnt == LAST_IDLE) begin
                        r_ready   <= 1'b0;
                        r_standby <= 1'b1;
                        r_state   <= ST_STANDBY;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                ST_ACCESS: begin
                    r_cs   <= 1'b0;
                    r_wren <= 1'b0;
                    r_mask <= '0;
                    if (r_write) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= w_ld_data;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_STANDBY: begin
                    if (bus.req_valid) begin
                        r_standby <= 1'b0;
                        r_state   <= ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
